layer_mac: RTL and testbench
============================

# layer_mac

Time-multiplexed fully connected layer that sits directly downstream of `input_aggregator`. On each `start` it latches the aggregator's input vector and weight matrix, forms NEURON_NUM dot products serially over NEURON_NUM cycles using one multiplier per neuron, then applies ReLU, fixed-point rescale and saturation. It returns the result vector with a one-cycle valid pulse that drives the aggregator's `layer_input` / `layer_input_valid`.

## Interface

- NEURON_NUM, 6, neurons per layer and inputs per neuron.
- NEURON_OUTPUT, 9, bits per input/output element; unsigned, FRACTION fractional bits.
- WEIGHT_SIZE, 17, bits per weight; two's complement, FRACTION fractional bits.
- FRACTION, 8, fractional bits removed after accumulation.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; connects to aggregator `layer_start`.
- inputs  in  NEURON_NUM*NEURON_OUTPUT (54)  input k at [k*NEURON_OUTPUT +: NEURON_OUTPUT]; connects to `out_inputs`.
- weights  in  NEURON_NUM*NEURON_NUM*WEIGHT_SIZE (612)  w[n][k] at [(n*NEURON_NUM+k)*WEIGHT_SIZE +: WEIGHT_SIZE]; connects to `out_weights`.
- result  out  NEURON_NUM*NEURON_OUTPUT (54)  neuron n at [n*NEURON_OUTPUT +: NEURON_OUTPUT]; registered and held until the next completion.
- result_valid  out  1  one-cycle pulse when `result` updates.
- busy  out  1  high whenever state != IDLE.

## Operation

- States: IDLE, MAC, ACT.
- IDLE:
  - When `start`=1: latch `inputs` and `weights` into internal registers, clear all accumulators, set k=0, go to MAC.
  - The ports are not sampled again during the operation.
- MAC:
  - Each cycle, for every n: acc[n] += {1'b0,in[k]} * signed w[n][k].
  - acc is 32-bit signed, so there is no overflow.
  - k increments each cycle; after k=NEURON_NUM-1 go to ACT.
- ACT, computed per neuron:
  - If acc[n] < 0: 0.
  - Otherwise acc[n] >>> FRACTION, truncated (floor).
  - If that exceeds 2^NEURON_OUTPUT-1 (511): 511.
  - Register the result, pulse `result_valid`, return to IDLE.
- `start` while busy: ignored, no queuing.
- `start` in the IDLE cycle in which `result_valid` is high: accepted normally.
- `rst`:
  - Takes priority over everything, including mid-operation.
  - Resets to state IDLE, k=0, accumulators 0, `result`=0, `result_valid`=0, `busy`=0.
  - An aborted operation never produces `result_valid`.

## Timing

- Reset values: `result`=0, `result_valid`=0, `busy`=0.
- `start` sampled high at edge E:
  - `busy` is high from after E.
  - Accumulation happens at edges E+1..E+NEURON_NUM, with k=0..NEURON_NUM-1.
  - ACT occupies the cycle ending at edge E+NEURON_NUM+1.
- At edge E+NEURON_NUM+1 (E+7 by default): `result` updates, `result_valid` goes to 1, `busy` goes to 0.
- At edge E+NEURON_NUM+2: `result_valid` returns to 0.
- Latency is 7 cycles start-to-valid. Back-to-back throughput is one layer per 7 cycles.
- `result` stays stable between pulses.

## Test plan

- Identity: all inputs 256; w[n][n]=256, others 0; pulse `start` -> exactly 7 cycles later `result_valid` pulses once, every element = 256, `busy` falls on the same edge.
- Ramp and sum: in[k]=16*k; neuron 0 weights all 256; neuron 1 weights all −256; others 0 -> result[0]=240, result[1]=0 (ReLU), others 0.
- Saturation: all inputs 511; all weights 0x0FFFF (65535) -> every element = 511. Weights 0x10000 (−65536) -> every element = 0.
- Busy protection:
  - Start a layer, then pulse `start` at cycles 2 and 6 with different operands -> a single valid at +7 carrying the first operands' result.
  - Then pulse `start` in the valid cycle -> second valid 7 cycles later.
- Reset mid-operation: assert `rst` at cycle 3 of MAC -> `busy`=0, `result`=0, no valid pulse. A subsequent `start` with the identity stimulus gives 256 after 7 cycles.
- Integration with `input_aggregator`:
  - Chain `layer_start`→`start`, `out_inputs`/`out_weights`→`inputs`/`weights`, `result`/`result_valid`→`layer_input`/`layer_input_valid`.
  - Pulse the aggregator `start` -> `layer_num` advances on each valid and each layer takes 7 cycles.

Source files
------------

// File: rtl/layer_mac.sv
// ---------------------------------------------------------------------------
// layer_mac
//
// A time-multiplexed, fully connected neural-network layer. It sits directly
// downstream of input_aggregator.
//
// On `start`, the block latches the input vector and the weight matrix. It
// then forms NEURON_NUM dot products in parallel, one input element per
// cycle, using one multiplier per neuron. After that it applies ReLU, drops
// FRACTION fractional bits (floor), and saturates to NEURON_OUTPUT bits.
//
// Ports
//   clk          : rising-edge clock
//   rst          : synchronous, active-high reset
//   start        : one-cycle request; accepted only when idle
//   inputs       : NEURON_NUM unsigned elements, element k at [k*NO +: NO]
//   weights      : signed w[n][k] at [(n*NEURON_NUM+k)*WS +: WS]
//   result       : registered result vector, neuron n at [n*NO +: NO]
//   result_valid : one-cycle pulse when `result` updates
//   busy         : high whenever the FSM is not idle
//   dbg_state    : current FSM state (0 idle, 1 mac, 2 act)
//
// Handshake: `start` has no ready. It is a request that takes effect only
// in a cycle where busy=0; any request while busy=1 is dropped. Each
// accepted request produces exactly one result_valid pulse, NEURON_NUM+1
// cycles later, unless rst intervenes.
// ---------------------------------------------------------------------------
module layer_mac #(
  parameter int NEURON_NUM    = 6,
  parameter int NEURON_OUTPUT = 9,
  parameter int WEIGHT_SIZE   = 17,
  parameter int FRACTION      = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [NEURON_NUM*NEURON_OUTPUT-1:0]        inputs,
  input  logic [NEURON_NUM*NEURON_NUM*WEIGHT_SIZE-1:0] weights,
  output logic [NEURON_NUM*NEURON_OUTPUT-1:0]        result,
  output logic                                       result_valid,
  output logic                                       busy,
  output logic [1:0]                                 dbg_state
);

  localparam int NO = NEURON_OUTPUT;
  localparam int WS = WEIGHT_SIZE;
  localparam int KW = (NEURON_NUM > 1) ? $clog2(NEURON_NUM) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NEURON_NUM - 1);
  localparam logic signed [31:0] MAX_OUT = 32'((1 << NO) - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    ACT  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic [NO-1:0]            in_q  [NEURON_NUM];
  logic [NO-1:0]            in_d  [NEURON_NUM];
  logic [WS-1:0]            w_q   [NEURON_NUM][NEURON_NUM];
  logic [WS-1:0]            w_d   [NEURON_NUM][NEURON_NUM];
  logic signed [31:0]       acc_q [NEURON_NUM];
  logic signed [31:0]       acc_d [NEURON_NUM];
  logic [NEURON_NUM*NO-1:0] result_q, result_d;
  logic                     valid_q, valid_d;

  // The input element is zero-extended, so it stays non-negative in the
  // signed product. The weight is sign-extended. Both are widened to 32 bits
  // so that the product and the running sum share one width.
  function automatic logic signed [31:0] mac_term(input logic [NO-1:0] x,
                                                  input logic [WS-1:0] w);
    logic signed [31:0] xs;
    logic signed [31:0] ws;
    xs = $signed({{(32-NO){1'b0}}, x});
    ws = $signed({{(32-WS){w[WS-1]}}, w});
    return xs * ws;
  endfunction

  // Negative sums clamp to 0 (ReLU). Non-negative sums drop FRACTION bits
  // (floor) and saturate at the all-ones output code.
  function automatic logic [NO-1:0] activate(input logic signed [31:0] acc);
    logic signed [31:0] sh;
    sh = acc >>> FRACTION;
    if (acc < 0)             return '0;
    else if (sh > MAX_OUT)   return '1;
    else                     return sh[NO-1:0];
  endfunction

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    in_d     = in_q;
    w_d      = w_q;
    acc_d    = acc_q;
    result_d = result_q;
    valid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          for (int k = 0; k < NEURON_NUM; k++) begin
            in_d[k] = inputs[k*NO +: NO];
          end
          for (int n = 0; n < NEURON_NUM; n++) begin
            for (int k = 0; k < NEURON_NUM; k++) begin
              w_d[n][k] = weights[(n*NEURON_NUM+k)*WS +: WS];
            end
            acc_d[n] = '0;
          end
          k_d     = '0;
          state_d = MAC;
        end
      end

      MAC: begin
        for (int n = 0; n < NEURON_NUM; n++) begin
          acc_d[n] = acc_q[n] + mac_term(in_q[k_q], w_q[n][k_q]);
        end
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = ACT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      ACT: begin
        for (int n = 0; n < NEURON_NUM; n++) begin
          result_d[n*NO +: NO] = activate(acc_q[n]);
        end
        valid_d = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      in_q     <= '{default: '0};
      w_q      <= '{default: '{default: '0}};
      acc_q    <= '{default: '0};
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      in_q     <= in_d;
      w_q      <= w_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;
  assign busy         = (state_q != IDLE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_layer_mac.sv
// ---------------------------------------------------------------------------
// tb_layer_mac
//
// Exercises layer_mac with:
//   - a table of directed vectors, some with hand-computed expectations;
//   - randomized vectors, whose expectations come from a plain-arithmetic
//     reference model;
//   - hand-written sequences for the multi-cycle cases: start while busy,
//     start in the valid cycle, and reset mid-operation.
// ---------------------------------------------------------------------------
module tb_layer_mac;

  localparam int NN = 6;
  localparam int NO = 9;
  localparam int WS = 17;
  localparam int IW = NN*NO;
  localparam int WW = NN*NN*WS;

  logic          clk;
  logic          rst;
  logic          start;
  logic [IW-1:0] inputs;
  logic [WW-1:0] weights;
  logic [IW-1:0] result;
  logic          result_valid;
  logic          busy;
  logic [1:0]    dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [IW-1:0] exp_q[$];

  layer_mac dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .inputs       (inputs),
    .weights      (weights),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each neuron's value is its dot product, computed as an exact integer.
  // Negative sums become 0. Otherwise the sum is divided by 2^8 (floor,
  // since the sum is non-negative) and capped at 511.
  function automatic logic [IW-1:0] model(input logic [IW-1:0] in_v,
                                          input logic [WW-1:0] w_v);
    logic [IW-1:0]      r;
    logic [NO-1:0]      iv;
    logic signed [WS-1:0] wv;
    longint             s;
    longint             q;
    r = '0;
    for (int n = 0; n < NN; n++) begin
      s = 0;
      for (int k = 0; k < NN; k++) begin
        iv = in_v[k*NO +: NO];
        wv = w_v[(n*NN+k)*WS +: WS];
        s += longint'(iv) * longint'(wv);
      end
      if (s < 0) q = 0;
      else begin
        q = s / 256;
        if (q > 511) q = 511;
      end
      r[n*NO +: NO] = NO'(q);
    end
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [IW-1:0] fill_in(input logic [NO-1:0] v);
    logic [IW-1:0] r;
    for (int k = 0; k < NN; k++) r[k*NO +: NO] = v;
    return r;
  endfunction

  function automatic logic [WW-1:0] fill_w(input logic [WS-1:0] v);
    logic [WW-1:0] r;
    for (int i = 0; i < NN*NN; i++) r[i*WS +: WS] = v;
    return r;
  endfunction

  function automatic logic [WW-1:0] diag_w(input logic [WS-1:0] v);
    logic [WW-1:0] r;
    r = '0;
    for (int n = 0; n < NN; n++) r[(n*NN+n)*WS +: WS] = v;
    return r;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drives start for one cycle. The task returns at the negedge just after
  // the accepting edge E.
  task automatic do_start(input logic [IW-1:0] in_v, input logic [WW-1:0] w_v);
    @(negedge clk);
    inputs  = in_v;
    weights = w_v;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Counts negedges until result_valid is seen. The wait is bounded.
  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!result_valid && lat < 20);
    if (!result_valid) begin
      check({name, "_valid_timeout"}, 64'd0, 64'd1);
      lat = -1;
    end
  endtask

  task automatic run_vec(input string name, input logic [IW-1:0] in_v,
                         input logic [WW-1:0] w_v, input logic [IW-1:0] exp_v);
    int lat;
    logic [IW-1:0] e;
    exp_q.push_back(exp_v);
    do_start(in_v, w_v);
    check({name, "_busy_rise"}, 64'(busy), 64'd1);
    // Scramble the ports; the block must work from its latched copy.
    inputs  = ~in_v;
    weights = ~w_v;
    wait_valid(name, lat);
    e = exp_q.pop_front();
    if (lat > 0) begin
      check({name, "_latency"}, 64'(lat), 64'd7);
      check({name, "_busy_fall"}, 64'(busy), 64'd0);
      check({name, "_result"}, 64'(result), 64'(e));
      @(negedge clk);
      check({name, "_valid_pulse"}, 64'(result_valid), 64'd0);
      check({name, "_result_hold"}, 64'(result), 64'(e));
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string         name;
    logic [IW-1:0] in_v;
    logic [WW-1:0] w_v;
    logic [IW-1:0] exp_v;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vec_t v;
    logic [IW-1:0] id_exp;
    logic [IW-1:0] ramp_in;
    logic [WW-1:0] ramp_w;
    logic [IW-1:0] ramp_exp;
    logic [IW-1:0] a_in, b_in, a_exp, b_exp;
    logic [WW-1:0] a_w, b_w;
    int lat;
    int nvalid;
    int vcyc;

    rst = 1'b1; start = 1'b0; inputs = '0; weights = '0;

    // Identity: every element is 1.0 and the diagonal is 1.0 -> 256 each.
    id_exp = fill_in(9'd256);
    v.name = "identity"; v.in_v = fill_in(9'd256); v.w_v = diag_w(17'd256);
    v.exp_v = id_exp; vecs.push_back(v);

    // Ramp: in[k] = 16*k. Neuron 0 sums with weight +1.0, neuron 1 with -1.0.
    ramp_in = '0;
    for (int k = 0; k < NN; k++) ramp_in[k*NO +: NO] = NO'(16*k);
    ramp_w = '0;
    for (int k = 0; k < NN; k++) begin
      ramp_w[(0*NN+k)*WS +: WS] = 17'd256;
      ramp_w[(1*NN+k)*WS +: WS] = 17'h1FF00;   // -256
    end
    ramp_exp = '0;
    ramp_exp[0 +: NO] = 9'd240;
    v.name = "ramp"; v.in_v = ramp_in; v.w_v = ramp_w; v.exp_v = ramp_exp;
    vecs.push_back(v);

    v.name = "sat_hi"; v.in_v = fill_in(9'd511); v.w_v = fill_w(17'h0FFFF);
    v.exp_v = fill_in(9'd511); vecs.push_back(v);
    v.name = "sat_lo"; v.in_v = fill_in(9'd511); v.w_v = fill_w(17'h10000);
    v.exp_v = '0; vecs.push_back(v);
    v.name = "zero_in"; v.in_v = '0; v.w_v = fill_w(17'h0FFFF);
    v.exp_v = '0; vecs.push_back(v);
    // Just below one output LSB: 1*255 / 256 floors to 0; 1*256 -> 1.
    v.name = "floor"; v.in_v = fill_in(9'd1); v.w_v = diag_w(17'd255);
    v.exp_v = '0; vecs.push_back(v);

    // Random vectors: even iterations use small weights (mostly unsaturated),
    // odd iterations use the full weight range.
    for (int i = 0; i < 12; i++) begin
      v.name = $sformatf("rand%0d", i);
      for (int k = 0; k < NN; k++) v.in_v[k*NO +: NO] = NO'($urandom_range(0, 511));
      for (int j = 0; j < NN*NN; j++) begin
        if (i % 2 == 0) v.w_v[j*WS +: WS] = WS'($urandom_range(0, 600)) - WS'(200);
        else            v.w_v[j*WS +: WS] = WS'($urandom_range(0, 131071));
      end
      v.exp_v = model(v.in_v, v.w_v);
      vecs.push_back(v);
    end

    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    check("reset_busy_in_rst", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_result", 64'(result), 64'd0);
    check("reset_valid", 64'(result_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);

    // ---------------- table ----------------
    foreach (vecs[i]) run_vec(vecs[i].name, vecs[i].in_v, vecs[i].w_v, vecs[i].exp_v);

    // ---------------- start while busy ----------------
    a_in = fill_in(9'd256); a_w = diag_w(17'd256); a_exp = id_exp;
    b_in = ramp_in;         b_w = ramp_w;          b_exp = ramp_exp;
    do_start(a_in, a_w);
    nvalid = 0; vcyc = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (result_valid) begin
        nvalid++;
        vcyc = c;
        check("busy_prot_result", 64'(result), 64'(a_exp));
      end
      // Driven here, so these are sampled at cycles 2 and 6 after E.
      inputs  = b_in;
      weights = b_w;
      start   = (c == 1 || c == 5);
    end
    start = 1'b0;
    check("busy_prot_nvalid", 64'(nvalid), 64'd1);
    check("busy_prot_cycle", 64'(vcyc), 64'd7);

    // ---------------- start in the valid cycle ----------------
    do_start(a_in, a_w);
    wait_valid("b2b_first", lat);
    check("b2b_first_result", 64'(result), 64'(a_exp));
    inputs = b_in; weights = b_w; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    wait_valid("b2b_second", lat);
    check("b2b_latency", 64'(lat), 64'd7);
    check("b2b_second_result", 64'(result), 64'(b_exp));

    // ---------------- reset mid-operation ----------------
    do_start(b_in, b_w);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_valid", 64'(result_valid), 64'd0);
    nvalid = 0;
    repeat (10) begin
      @(negedge clk);
      if (result_valid) nvalid++;
    end
    check("midrst_no_valid", 64'(nvalid), 64'd0);
    check("midrst_idle_result", 64'(result), 64'd0);
    run_vec("post_rst_identity", fill_in(9'd256), diag_w(17'd256), id_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog. If it expires, it reports the hang and then stops the run.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
